dmem_lsu: RTL and testbench

- Load/store unit that initiates accesses on the single-port data memory interface (sync write, async read, word-indexed by address bits [31:2]).
- Accepts byte/half/word load and store requests from the core through a valid/ready handshake.
- Performs sign/zero extension on loads and read-modify-write merges on sub-word stores.
- Flags misaligned, illegal-size and out-of-range accesses without touching memory.

---
 rtl/dmem_lsu_if.sv | 25 ++
 rtl/dmem_lsu.sv | 66 ++++++
 tb/tb_dmem_lsu.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core request/response and data-memory bus bundle for the load/store unit
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit with sub-word read-modify-write and access checking
module dmem_lsu #(
    parameter int MEM_WORDS = 64
) (
    input  logic clk,
    input  logic rst_n,
    dmem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
    state_t state, state_nx;
    logic [31:0] addr_q;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic        err;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ext, mask, merged;
    assign err = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                 ({2'b00, addr_q[31:2]} >= 32'(MEM_WORDS));
    assign lb = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
    assign lh = bus.mem_rd[{addr_q[1], 4'b0000} +: 16];
    assign ext = size_q == 2'b00 ? {{24{~uns_q & lb[7]}}, lb} :
                 size_q == 2'b01 ? {{16{~uns_q & lh[15]}}, lh} : bus.mem_rd;
    // mem_wd still holds the raw store data during ACCESS, so it feeds the merge
    assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << {addr_q[1:0], 3'b000};
    assign merged = (bus.mem_rd & ~mask) |
                    ((size_q == 2'b00 ? {4{bus.mem_wd[7:0]}} : {2{bus.mem_wd[15:0]}}) & mask);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE   ? (bus.req_valid ? ACCESS : IDLE) :
                   state == ACCESS ? ((err || !we_q || size_q == 2'b10) ? RESP : WRITE) :
                   state == WRITE  ? RESP : IDLE;
    end
    always_comb begin
        bus.req_ready  = state == IDLE;
        bus.resp_valid = state == RESP;
        bus.resp_err   = state == RESP && err_q;
        bus.mem_we     = (state == ACCESS && we_q && size_q == 2'b10 && !err) || state == WRITE;
        bus.mem_a      = {addr_q[31:2], 2'b00};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            size_q         <= 2'b00;
            err_q          <= 1'b0;
            bus.mem_wd     <= '0;
            bus.resp_rdata <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            addr_q     <= bus.req_addr;
            we_q       <= bus.req_we;
            uns_q      <= bus.req_unsigned;
            size_q     <= bus.req_size;
            bus.mem_wd <= bus.req_wdata;
        end else if (state == ACCESS) begin
            err_q          <= err;
            bus.resp_rdata <= (!we_q && !err) ? ext : '0;
            if (we_q && size_q != 2'b10 && !err) bus.mem_wd <= merged;
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: table, corner-sequence and random checks of dmem_lsu against a word-array model
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    dmem_lsu_if b();
    dmem_lsu #(.MEM_WORDS(64)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;

    logic [31:0] mem [64] = '{default: 32'h0};
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    assign b.mem_rd = (b.mem_a[31:8] == 24'h0) ? mem[b.mem_a[7:2]] : 32'hA5A5A5A5;
    always @(posedge clk) if (b.mem_we && b.mem_a[31:8] == 24'h0) mem[b.mem_a[7:2]] <= b.mem_wd;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        ee;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ready"}, b.req_ready, 1);
        chk({nm, "_rvalid"}, b.resp_valid, 0);
        chk({nm, "_rerr"}, b.resp_err, 0);
        chk({nm, "_we"}, b.mem_we, 0);
        chk({nm, "_mem_a"}, b.mem_a, 0);
        chk({nm, "_mem_wd"}, b.mem_wd, 0);
        chk({nm, "_rdata"}, b.resp_rdata, 0);
    endtask

    // Reference: memory as an array of words, lanes picked by shifting by 8*offset
    task automatic model(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat, output int wn, output logic [31:0] nw);
        int k;
        logic [31:0] w, v, m;
        k = int'(a[1:0]);
        e = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0) || a[31:2] >= 64;
        rd = 0; lat = 2; wn = 0; nw = 0;
        m = sz == 0 ? 32'hFF : 32'hFFFF;
        if (!e) begin
            w = ref_mem[a[7:2]];
            if (!we) begin
                if (sz == 2) rd = w;
                else begin
                    v = (w >> (8 * k)) & m;
                    rd = (u || (sz == 0 ? !v[7] : !v[15])) ? v : (v | ~m);
                end
            end else begin
                nw = sz == 2 ? wd : ((w & ~(m << (8 * k))) | ((wd & m) << (8 * k)));
                ref_mem[a[7:2]] = nw;
                wn = sz == 2 ? 1 : 2;
                lat = sz == 2 ? 2 : 3;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat, output int wn, output int wc, output logic [31:0] wa,
                          output logic [31:0] wdat, output int rh);
        rd = 0; e = 0; lat = 0; wn = 0; wc = 0; wa = 0; wdat = 0; rh = 0;
        @(negedge clk);
        chk("ready_idle", b.req_ready, 1);
        b.req_we = we; b.req_size = sz; b.req_unsigned = u; b.req_addr = a; b.req_wdata = wd;
        b.req_valid = 1'b1;
        @(posedge clk);
        #1 b.req_valid = 1'b0;
        b.req_wdata = ~wd;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (b.mem_we) begin wc++; wn = n; wa = b.mem_a; wdat = b.mem_wd; end
            if (b.req_ready) rh++;
            if (b.resp_valid) begin lat = n; rd = b.resp_rdata; e = b.resp_err; end
        end
    endtask

    task automatic run(input string nm, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd, output logic e);
        logic [31:0] xrd, xw, wa, wdat;
        logic xe;
        int xl, xwn, lat, wn, wc, rh;
        model(we, sz, u, a, wd, xrd, xe, xl, xwn, xw);
        do_req(we, sz, u, a, wd, rd, e, lat, wn, wc, wa, wdat, rh);
        chk({nm, "_err"}, e, xe);
        chk({nm, "_rdata"}, rd, xrd);
        chk({nm, "_latency"}, lat, xl);
        chk({nm, "_we_count"}, wc, xwn != 0 ? 1 : 0);
        chk({nm, "_ready_busy"}, rh, 0);
        if (xwn != 0) begin
            chk({nm, "_we_cycle"}, wn, xwn);
            chk({nm, "_we_addr"}, wa, {a[31:2], 2'b00});
            chk({nm, "_we_data"}, wdat, xw);
        end
    endtask

    initial begin
        logic [31:0] rd, ga;
        logic e;
        int i, resp, bad;
        logic [31:0] q_rd [$];
        logic q_e [$];
        int q_t [$];
        vec_t bb [3];
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'h777777AB, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11AB3344, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h20,  32'h80F07F01, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h23,  32'h0,        32'hFFFFFF80, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h23,  32'h0,        32'h00000080, 1'b0};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'hFFFF80F0, 1'b0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h20,  32'h0,        32'h00007F01, 1'b0};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h13,  32'h5555,     32'h0,        1'b1};
        tbl[12] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'h12345678, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11AB3344, 1'b0};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h80F07F01, 1'b0};
        b.req_valid = 0; b.req_we = 0; b.req_size = 0; b.req_unsigned = 0;
        b.req_addr = 0; b.req_wdata = 0;
        #3 chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int t = 0; t < 16; t++) begin
            run($sformatf("vec%0d", t), tbl[t].we, tbl[t].sz, tbl[t].u, tbl[t].a, tbl[t].wd, rd, e);
            chk($sformatf("vec%0d_table_rdata", t), rd, tbl[t].erd);
            chk($sformatf("vec%0d_table_err", t), e, tbl[t].ee);
        end

        // Reset during the ACCESS cycle of a half store must leave memory untouched
        @(negedge clk);
        b.req_we = 1; b.req_size = 1; b.req_unsigned = 0; b.req_addr = 32'h10; b.req_wdata = 32'h9999;
        b.req_valid = 1'b1;
        @(posedge clk);
        #1 b.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("abort");
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (b.mem_we || b.resp_valid) bad++;
        end
        chk("abort_quiet", bad, 0);
        rst_n = 1'b1;
        run("abort_readback", 0, 2, 0, 32'h10, 0, rd, e);
        chk("abort_word", rd, 32'h11AB3344);

        // Three requests with req_valid held high
        bb[0] = '{1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0};
        bb[1] = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0,        32'h0, 1'b0};
        bb[2] = '{1'b1, 2'd0, 1'b0, 32'h31, 32'h00000055, 32'h0, 1'b0};
        i = 0; resp = 0;
        for (int c = 0; c < 40 && resp < 3; c++) begin
            @(negedge clk);
            if (b.resp_valid) begin
                chk("b2b_ready_low", b.req_ready, 0);
                if (q_t.size() == 0) chk("b2b_spurious_resp", 1, 0);
                else begin
                    chk("b2b_rdata", b.resp_rdata, q_rd.pop_front());
                    chk("b2b_err", b.resp_err, q_e.pop_front());
                    chk("b2b_time", c, q_t.pop_front());
                end
                resp++;
            end
            if (b.req_ready) begin
                if (i < 3) begin
                    logic [31:0] xrd, xw;
                    logic xe;
                    int xl, xwn;
                    b.req_we = bb[i].we; b.req_size = bb[i].sz; b.req_unsigned = bb[i].u;
                    b.req_addr = bb[i].a; b.req_wdata = bb[i].wd; b.req_valid = 1'b1;
                    model(bb[i].we, bb[i].sz, bb[i].u, bb[i].a, bb[i].wd, xrd, xe, xl, xwn, xw);
                    q_rd.push_back(xrd); q_e.push_back(xe); q_t.push_back(c + xl);
                    i++;
                end else b.req_valid = 1'b0;
            end
        end
        b.req_valid = 1'b0;
        chk("b2b_responses", resp, 3);
        run("b2b_readback", 0, 2, 0, 32'h30, 0, rd, e);
        chk("b2b_word", rd, 32'hCAFE550D);

        for (int t = 0; t < 300; t++) begin
            int idx;
            idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(64, 70)) :
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
            ga = {idx[29:0], 2'(($urandom_range(0, 3)))};
            run($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ga, $urandom, rd, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
